// File: rtl/mem_pkg.sv
// Shared types and constants for the compute-memory arbiter.
// Owner encoding, requester IDs and the per-requester access payload.
package mem_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } own_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

    // One requester's access as presented to the memory pins.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic own_state_e owner_of(input req_id_t id);
        return (id == REQ_A) ? OWN_A : OWN_B;
    endfunction

endpackage

// File: rtl/rd_return.sv
// Per-requester read-return stage: captures memory data at the end of a read
// access and pulses valid for the following cycle.
module rd_return
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DATA_W-1:0] mem_out,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    // rdata holds until the next read by this requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= capture;
            if (capture) begin
                rdata_q <= mem_out;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter with bounded lock for the single-port
// 128x32 compute memory; A is the compute circuit, B the host load/dump path.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_a,
    input  logic              lock_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,

    input  logic              req_b,
    input  logic              lock_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,

    output logic [ADDR_W-1:0] mem_index,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,

    output logic              busy
);

    localparam int unsigned LOCK_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

    own_state_e        state_q;
    req_id_t           rr_ptr_q;
    logic [LOCK_W-1:0] lock_cnt_q;

    logic       own_req_c;
    logic       own_lock_c;
    logic       oth_req_c;
    own_state_e oth_state_c;
    req_id_t    oth_id_c;
    logic       hold_c;

    logic       acc_a_c;
    logic       acc_b_c;
    mem_req_t   pay_a_c;
    mem_req_t   pay_b_c;
    mem_req_t   sel_c;

    assign gnt_a = (state_q == OWN_A);
    assign gnt_b = (state_q == OWN_B);
    assign busy  = (state_q != IDLE);

    assign acc_a_c = gnt_a && req_a;
    assign acc_b_c = gnt_b && req_b;

    // View of the current owner and its opponent, so both owner states share one rule set.
    always_comb begin
        own_req_c   = 1'b0;
        own_lock_c  = 1'b0;
        oth_req_c   = 1'b0;
        oth_state_c = IDLE;
        oth_id_c    = REQ_A;
        case (state_q)
            OWN_A: begin
                own_req_c   = req_a;
                own_lock_c  = lock_a;
                oth_req_c   = req_b;
                oth_state_c = owner_of(REQ_B);
                oth_id_c    = REQ_B;
            end
            OWN_B: begin
                own_req_c   = req_b;
                own_lock_c  = lock_b;
                oth_req_c   = req_a;
                oth_state_c = owner_of(REQ_A);
                oth_id_c    = REQ_A;
            end
            default: begin
            end
        endcase
    end

    // A locked owner keeps the bus until LOCK_MAX accesses under contention.
    assign hold_c = own_req_c && own_lock_c &&
                    ((lock_cnt_q < LOCK_LAST) || !oth_req_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= REQ_A;
            lock_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    lock_cnt_q <= '0;
                    if (req_a && req_b) begin
                        state_q <= owner_of(rr_ptr_q);
                    end else if (req_a) begin
                        state_q <= OWN_A;
                    end else if (req_b) begin
                        state_q <= OWN_B;
                    end
                end
                OWN_A, OWN_B: begin
                    if (hold_c) begin
                        if (lock_cnt_q != LOCK_LAST) begin
                            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                        end
                    end else if (oth_req_c) begin
                        // Direct handover; the side just served drops to lowest priority.
                        state_q    <= oth_state_c;
                        rr_ptr_q   <= oth_id_c;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= '0;
                        if (!own_req_c) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end

    assign pay_a_c = '{we: we_a, addr: addr_a, wdata: wdata_a};
    assign pay_b_c = '{we: we_b, addr: addr_b, wdata: wdata_b};

    // Memory pins carry the owner's access, and are zero when no access occurs.
    always_comb begin
        sel_c = '0;
        if (acc_a_c) begin
            sel_c = pay_a_c;
        end else if (acc_b_c) begin
            sel_c = pay_b_c;
        end
    end

    assign mem_index = sel_c.addr;
    assign mem_wr    = sel_c.we;
    assign mem_in    = sel_c.wdata;

    rd_return u_ret_a (
        .clk     (clk),
        .rst     (rst),
        .capture (acc_a_c && !we_a),
        .mem_out (mem_out),
        .rdata_o (rdata_a),
        .rvalid_o(rvalid_a)
    );

    rd_return u_ret_b (
        .clk     (clk),
        .rst     (rst),
        .capture (acc_b_c && !we_b),
        .mem_out (mem_out),
        .rdata_o (rdata_b),
        .rvalid_o(rvalid_b)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: attached word memory, a rule-level ownership model
// checked every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int LOCK_LIM = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_a = 1'b0, lock_a = 1'b0, we_a = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0;
    logic [DATA_W-1:0] wdata_a = '0;
    logic              req_b = 1'b0, lock_b = 1'b0, we_b = 1'b0;
    logic [ADDR_W-1:0] addr_b = '0;
    logic [DATA_W-1:0] wdata_b = '0;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wr, busy;
    logic [DATA_W-1:0] rdata_a, rdata_b, mem_in, mem_out;
    logic [ADDR_W-1:0] mem_index;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.LOCK_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .lock_a(lock_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .lock_b(lock_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .mem_index(mem_index), .mem_wr(mem_wr), .mem_in(mem_in), .mem_out(mem_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT pins; ref_mem is the model's own copy.
    logic [DATA_W-1:0] tb_mem  [128];
    logic [DATA_W-1:0] ref_mem [128];

    initial begin
        for (int i = 0; i < 128; i++) begin
            tb_mem[i]  <= {16'hA5A5, 16'(i)};
            ref_mem[i] = {16'hA5A5, 16'(i)};
        end
        tb_mem[5]  <= 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
    end

    assign mem_out = tb_mem[mem_index];
    always @(posedge clk) if (mem_wr) tb_mem[mem_index] <= mem_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner 0=none 1=A 2=B; rr 0=A 1=B; streak = locked holds under the current owner.
    logic              m_on = 1'b0;
    int                m_own = 0, m_rr = 0, m_streak = 0;
    logic              m_rvalid_a = 1'b0, m_rvalid_b = 1'b0;
    logic [DATA_W-1:0] m_rdata_a = '0, m_rdata_b = '0;
    logic              m_acc_a, m_acc_b, my_req, my_lock, oth_req;
    int                other;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1; m_own = 0; m_rr = 0; m_streak = 0;
            m_rvalid_a = 1'b0; m_rvalid_b = 1'b0;
            m_rdata_a = '0; m_rdata_b = '0;
        end else if (m_on) begin
            m_acc_a = (m_own == 1) && req_a;
            m_acc_b = (m_own == 2) && req_b;
            m_rvalid_a = m_acc_a && !we_a;
            m_rvalid_b = m_acc_b && !we_b;
            if (m_acc_a) begin
                if (we_a) ref_mem[addr_a] = wdata_a; else m_rdata_a = ref_mem[addr_a];
            end
            if (m_acc_b) begin
                if (we_b) ref_mem[addr_b] = wdata_b; else m_rdata_b = ref_mem[addr_b];
            end
            if (m_own == 0) begin
                m_streak = 0;
                if (req_a && req_b) m_own = m_rr + 1;
                else if (req_a) m_own = 1;
                else if (req_b) m_own = 2;
            end else begin
                my_req  = (m_own == 1) ? req_a  : req_b;
                my_lock = (m_own == 1) ? lock_a : lock_b;
                oth_req = (m_own == 1) ? req_b  : req_a;
                other   = 3 - m_own;
                if (my_req && my_lock && (m_streak < LOCK_LIM - 1 || !oth_req)) begin
                    if (m_streak < LOCK_LIM - 1) m_streak = m_streak + 1;
                end else if (oth_req) begin
                    m_own = other; m_rr = other - 1; m_streak = 0;
                end else begin
                    m_streak = 0;
                    if (!my_req) m_own = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_on) begin
            automatic logic ea = (m_own == 1) && req_a;
            automatic logic eb = (m_own == 2) && req_b;
            automatic logic [ADDR_W-1:0] ei = ea ? addr_a : (eb ? addr_b : '0);
            automatic logic              ew = ea ? we_a : (eb ? we_b : 1'b0);
            automatic logic [DATA_W-1:0] ed = ea ? wdata_a : (eb ? wdata_b : '0);
            chk("m_gnt_a", 32'(gnt_a), 32'(m_own == 1));
            chk("m_gnt_b", 32'(gnt_b), 32'(m_own == 2));
            chk("m_busy", 32'(busy), 32'(m_own != 0));
            chk("m_mem_index", 32'(mem_index), 32'(ei));
            chk("m_mem_wr", 32'(mem_wr), 32'(ew));
            chk("m_mem_in", mem_in, ed);
            chk("m_rvalid_a", 32'(rvalid_a), 32'(m_rvalid_a));
            chk("m_rvalid_b", 32'(rvalid_b), 32'(m_rvalid_b));
            chk("m_rdata_a", rdata_a, m_rdata_a);
            chk("m_rdata_b", rdata_b, m_rdata_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_a = 1'b0; lock_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; lock_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    endtask

    task automatic do_reset();
        step(); rst = 1'b1; clear_inputs();
        step(); rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single read by A from reset.
        rst = 1'b1;
        step(); step();
        rst = 1'b0; req_a = 1'b1; addr_a = 7'h05;
        samp();
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        step(); samp();
        chk("rd_gnt_a", 32'(gnt_a), 32'd1);
        chk("rd_mem_index", 32'(mem_index), 32'h05);
        chk("rd_mem_wr", 32'(mem_wr), 32'd0);
        step(); req_a = 1'b0; samp();
        chk("rd_rvalid_a", 32'(rvalid_a), 32'd1);
        chk("rd_rdata_a", rdata_a, 32'hDEADBEEF);
        chk("rd_gnt_b", 32'(gnt_b), 32'd0);
        chk("rd_rvalid_b", 32'(rvalid_b), 32'd0);
        step(); samp();
        chk("rd_rvalid_drop", 32'(rvalid_a), 32'd0);
        chk("rd_idle", 32'(busy), 32'd0);

        // Round-robin contention from reset.
        do_reset();
        req_a = 1'b1; addr_a = 7'h01; req_b = 1'b1; addr_b = 7'h02;
        for (int k = 1; k <= 6; k++) begin
            step(); samp();
            chk("rr_gnt_a", 32'(gnt_a), 32'(k % 2 == 1));
            chk("rr_index", 32'(mem_index), (k % 2 == 1) ? 32'h01 : 32'h02);
        end
        step(); clear_inputs();
        step(); step();

        // Locked read-modify-write by B.
        step(); req_b = 1'b1; lock_b = 1'b1; addr_b = 7'h10; samp();
        chk("rmw_c0_gnt_b", 32'(gnt_b), 32'd0);
        step(); samp();
        chk("rmw_c1_gnt_b", 32'(gnt_b), 32'd1);
        step(); samp();
        chk("rmw_c2_gnt_b", 32'(gnt_b), 32'd1);
        chk("rmw_c2_rdata_b", rdata_b, 32'hA5A50010);
        step(); we_b = 1'b1; wdata_b = 32'h1; samp();
        chk("rmw_c3_gnt_b", 32'(gnt_b), 32'd1);
        chk("rmw_c3_mem_wr", 32'(mem_wr), 32'd1);
        chk("rmw_c3_mem_in", mem_in, 32'h1);
        step(); clear_inputs(); samp();
        chk("rmw_mem16", tb_mem[16], 32'h1);
        chk("rmw_c4_mem_wr", 32'(mem_wr), 32'd0);
        step(); samp();
        chk("rmw_idle", 32'(busy), 32'd0);

        // Forced release after LOCK_MAX locked accesses.
        do_reset();
        req_a = 1'b1; lock_a = 1'b1; addr_a = 7'h03; req_b = 1'b1; addr_b = 7'h04;
        for (int k = 1; k <= 9; k++) begin
            step(); samp();
            chk("lock_gnt_a", 32'(gnt_a), 32'(k <= 8));
            chk("lock_gnt_b", 32'(gnt_b), 32'(k == 9));
        end
        step(); clear_inputs();
        step(); step();

        // Write by A then read of the same word by B on handover.
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 7'h20; wdata_a = 32'hCAFE0001;
        req_b = 1'b1; addr_b = 7'h20;
        step(); samp();
        chk("wr_gnt_a", 32'(gnt_a), 32'd1);
        chk("wr_mem_wr", 32'(mem_wr), 32'd1);
        chk("wr_mem_in", mem_in, 32'hCAFE0001);
        step(); req_a = 1'b0; we_a = 1'b0; samp();
        chk("ho_gnt_b", 32'(gnt_b), 32'd1);
        chk("ho_index", 32'(mem_index), 32'h20);
        step(); req_b = 1'b0; samp();
        chk("ho_rvalid_b", 32'(rvalid_b), 32'd1);
        chk("ho_rdata_b", rdata_b, 32'hCAFE0001);
        step(); step();

        // Reset while a read is granted.
        step(); req_a = 1'b1; addr_a = 7'h03; samp();
        step(); samp();
        chk("mr_gnt_a", 32'(gnt_a), 32'd1);
        step(); addr_a = 7'h04; rst = 1'b1; samp();
        chk("mr_rdata_a", rdata_a, 32'hA5A50003);
        step(); rst = 1'b0; req_a = 1'b0; samp();
        chk("mr_gnt_a_rst", 32'(gnt_a), 32'd0);
        chk("mr_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_mem_wr", 32'(mem_wr), 32'd0);
        chk("mr_rdata_zero", rdata_a, 32'd0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter for the single-port 128x32 word memory used by the compute circuit.
- Requester A is the compute circuit; requester B is the host load/dump path.
- Sits between both requesters and the memory's mem_index/mem_wr/mem_in/mem_out pins.
- Grants by round-robin, supports a bounded lock for read-modify-write sequences, and returns registered read data per requester.

Parameters:
ADDR_W, 7, memory word-address width
DATA_W, 32, memory data width
LOCK_MAX, 8, max consecutive accesses an owner may hold the bus via lock while the other side requests

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_a  in  1  requester A access request
lock_a  in  1  A requests to keep ownership after this access
we_a  in  1  A write enable (1 = write, 0 = read)
addr_a  in  ADDR_W  A word address
wdata_a  in  DATA_W  A write data
gnt_a  out  1  A owns the memory this cycle
rdata_a  out  DATA_W  A read data, registered
rvalid_a  out  1  one-cycle pulse, rdata_a valid
req_b, lock_b, we_b, addr_b, wdata_b, gnt_b, rdata_b, rvalid_b  same as the A ports, for requester B
mem_index  out  ADDR_W  memory address
mem_wr  out  1  memory write strobe
mem_in  out  DATA_W  memory write data
mem_out  in  DATA_W  memory read data, combinational from mem_index in the same cycle
busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE; rr_ptr = A; lock_cnt = 0.
  - gnt_a/b = 0; rvalid_a/b = 0; rdata_a/b = 0.
  - mem_wr = 0; mem_index = 0; mem_in = 0.
  - Reset mid-operation drops any pending rvalid and releases ownership immediately.
- States: IDLE, OWN_A, OWN_B.
- Outputs derived from registered state:
  - gnt_a = (state == OWN_A); gnt_b = (state == OWN_B).
  - busy = (state != IDLE).
- An access occurs in a cycle where gnt_x && req_x.
  - mem_index, mem_wr and mem_in are driven from the owner's addr_x, we_x and wdata_x.
  - When no access occurs: mem_wr = 0, mem_index = 0, mem_in = 0.
- Read latency:
  - On a read access, rdata_x <= mem_out at the clock edge ending that cycle.
  - rvalid_x pulses high for exactly the following cycle.
  - rdata_x holds its value until the next read by that requester.
  - Writes never pulse rvalid.
- Requester rule: hold req_x, addr_x, we_x and wdata_x stable until gnt_x is seen. Dropping req before grant is legal; the request is simply withdrawn.
- IDLE transitions:
  - Only req_a -> OWN_A; only req_b -> OWN_B.
  - Both -> owner given by rr_ptr.
  - Neither -> stay IDLE.
  - First grant appears the cycle after req.
- OWN_x transitions, evaluated every cycle:
  - Locked hold: req_x && lock_x && (lock_cnt < LOCK_MAX-1 || !req_other) -> stay; lock_cnt++ (saturating at LOCK_MAX-1).
  - Otherwise, if req_other -> OWN_other; lock_cnt = 0; rr_ptr = x's opposite side (the side just served gets lowest priority).
  - Otherwise, if req_x -> stay; lock_cnt = 0.
  - Otherwise -> IDLE; lock_cnt = 0.
- Handover costs no idle cycle: the last owner access and the new owner's grant are in consecutive cycles.
- Forced release: after LOCK_MAX consecutive locked accesses with the other side requesting, ownership moves regardless of lock_x.
- No requester is starved; worst-case wait is LOCK_MAX+1 cycles.
- Widths: all data paths are DATA_W with no arithmetic on data. lock_cnt is clog2(LOCK_MAX) bits and saturates.

Decomposition:
- Shared package, mem_pkg:
  - ADDR_W and DATA_W constants.
  - Owner state encoding: IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2.
  - Requester ID constants: REQ_A = 1'b0, REQ_B = 1'b1.
- One sub-module, rd_return: one instance per requester. Holds the rdata register and rvalid pulse, with inputs clk, rst, capture and mem_out.
- The FSM and mux stay in mem_arbiter.

Test Plan:
- Single read: after reset, A drives req_a=1, we_a=0, addr_a=7'h05 with mem[5]=32'hDEADBEEF -> gnt_a=1 in cycle 1, mem_index=5 and mem_wr=0 in cycle 1, rvalid_a=1 with rdata_a=32'hDEADBEEF in cycle 2; B outputs stay 0.
- Contention round-robin: req_a and req_b both high continuously, unlocked, from reset -> grants alternate A, B, A, B each cycle starting with A; mem_index alternates between addr_a and addr_b accordingly.
- Lock RMW: B holds lock_b=1 for 3 accesses (read 7'h10, read 7'h10, write 7'h10 = 32'h1) while A is idle -> gnt_b held for 3 cycles, mem[16]=1 afterwards, then IDLE once req_b drops.
- Forced release: A locked and requesting continuously, B requesting from cycle 0 -> gnt_a for exactly LOCK_MAX (8) cycles, then gnt_b in cycle 9.
- Simultaneous write/read handover: A writes 32'hCAFE0001 to 7'h20, B reads 7'h20 in the next granted cycle -> rdata_b=32'hCAFE0001.
- Reset mid-operation: rst=1 in the cycle a read is granted -> next cycle gnt_a=0, rvalid_a=0, busy=0, mem_wr=0, rdata_a=0.
